// File: rtl/meas_pkg.sv
// rtl/meas_pkg.sv - shared FSM state and mode encodings for the pulse counter
package meas_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LATCH   = 2'd2
  } state_e;

  localparam logic MODE_CONT   = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;
endpackage

// File: rtl/bit_synchronizer.sv
// rtl/bit_synchronizer.sv - multi-stage flop synchroniser for a vector of async bits
module bit_synchronizer #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];
endmodule

// File: rtl/multichannel_pulse_counter.sv
// rtl/multichannel_pulse_counter.sv - windowed high/low clock counter over one of NUM_CH pulse streams
module multichannel_pulse_counter
  import meas_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int CNT_W       = 24,
  parameter int WINDOW      = 20000,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [NUM_CH-1:0] cnt_in,
  input  logic [NUM_CH-1:0] cnt_en,
  input  logic              mode,
  input  logic              start,
  output logic [CNT_W-1:0]  count_p,
  output logic [CNT_W-1:0]  count_m,
  output logic [CH_W-1:0]   ch_out,
  output logic              overflow,
  output logic              valid,
  output logic              busy
);
  localparam int               WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CH_W:0]    NUM_CH_V = (CH_W + 1)'(NUM_CH);

  logic [2*NUM_CH-1:0] sync_w;
  logic [NUM_CH-1:0]   sync_in, sync_en;
  logic [CH_W-1:0]     ch_req, ch_d, ch_q;
  logic                sample_in_q, sample_en_q;
  logic [CNT_W-1:0]    acc_p_d, acc_p_q, acc_m_d, acc_m_q;
  logic                ovf_d, ovf_q;
  logic [WIN_W-1:0]    win_q;
  state_e              state_q;
  logic [CNT_W-1:0]    count_p_q, count_m_q;
  logic [CH_W-1:0]     ch_out_q;
  logic                overflow_q, valid_q, busy_q;

  bit_synchronizer #(
    .WIDTH (2 * NUM_CH),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   ({cnt_en, cnt_in}),
    .q_o   (sync_w)
  );

  assign sync_in = sync_w[NUM_CH-1:0];
  assign sync_en = sync_w[2*NUM_CH-1:NUM_CH];
  assign ch_req  = ({1'b0, ch_sel} < NUM_CH_V) ? ch_sel : '0;

  // Channel is frozen only inside a window; the sample stage follows the channel of the next cycle.
  assign ch_d = (state_q == MEASURE) ? ch_q : ch_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_q        <= '0;
      sample_in_q <= 1'b0;
      sample_en_q <= 1'b0;
    end else begin
      ch_q        <= ch_d;
      sample_in_q <= sync_in[ch_d];
      sample_en_q <= sync_en[ch_d];
    end
  end

  always_comb begin
    acc_p_d = acc_p_q;
    acc_m_d = acc_m_q;
    ovf_d   = ovf_q;
    if (sample_en_q) begin
      if (sample_in_q) begin
        if (acc_p_q == CNT_MAX) ovf_d = 1'b1;
        else                    acc_p_d = acc_p_q + 1'b1;
      end else begin
        if (acc_m_q == CNT_MAX) ovf_d = 1'b1;
        else                    acc_m_d = acc_m_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_p_q    <= '0;
      acc_m_q    <= '0;
      ovf_q      <= 1'b0;
      win_q      <= '0;
      count_p_q  <= '0;
      count_m_q  <= '0;
      ch_out_q   <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (mode == MODE_CONT || start) begin
            state_q <= MEASURE;
            busy_q  <= 1'b1;
            acc_p_q <= '0;
            acc_m_q <= '0;
            ovf_q   <= 1'b0;
            win_q   <= '0;
          end
        end
        MEASURE: begin
          acc_p_q <= acc_p_d;
          acc_m_q <= acc_m_d;
          ovf_q   <= ovf_d;
          win_q   <= win_q + 1'b1;
          if (win_q == WIN_LAST) begin
            state_q    <= LATCH;
            count_p_q  <= acc_p_d;
            count_m_q  <= acc_m_d;
            overflow_q <= ovf_d;
            ch_out_q   <= ch_q;
            valid_q    <= 1'b1;
          end
        end
        LATCH: begin
          acc_p_q <= '0;
          acc_m_q <= '0;
          ovf_q   <= 1'b0;
          win_q   <= '0;
          if (mode == MODE_CONT) begin
            state_q <= MEASURE;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign count_p  = count_p_q;
  assign count_m  = count_m_q;
  assign ch_out   = ch_out_q;
  assign overflow = overflow_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
endmodule
